// File: rtl/cash_dispenser.sv
// cash_dispenser: greedy two-denomination note splitter with paced ejects.
// Optional DISPENSER_AUDIT_EN adds a running total of dispensed amounts.
module cash_dispenser #(
  parameter logic [15:0] DENOM_HI      = 16'd100,
  parameter logic [15:0] DENOM_LO      = 16'd20,
  parameter logic [7:0]  CASSETTE_INIT = 8'd50,
  parameter int unsigned EJECT_GAP     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_amount,
  output logic        req_ready,
  input  logic        refill,
  output logic        eject_hi,
  output logic        eject_lo,
  output logic        done,
  output logic [1:0]  status,
  output logic [7:0]  hi_count,
  output logic [7:0]  lo_count
`ifdef DISPENSER_AUDIT_EN
  ,
  output logic [31:0] total_dispensed
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    DISP_HI,
    DISP_LO,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_OK     = 2'd0,
    ST_ZERO   = 2'd1,
    ST_UNSERV = 2'd2
  } status_e;

  localparam logic [15:0] GAP_M1 = 16'(EJECT_GAP - 1);

  state_e      state_q, state_n;
  logic [15:0] rem_q, rem_n;
  logic [7:0]  plan_hi_q, plan_hi_n;
  logic [7:0]  plan_lo_q, plan_lo_n;
  logic [7:0]  hi_q, hi_n;
  logic [7:0]  lo_q, lo_n;
  logic [15:0] gap_q, gap_n;
  logic        first_q, first_n;
  status_e     status_q, status_n;
  logic [15:0] amount_q, amount_n;
`ifdef DISPENSER_AUDIT_EN
  logic [31:0] total_q, total_n;
`endif

  // Handshake and strobes decode directly from state and pacing counter.
  always_comb begin
    req_ready = (state_q == IDLE) && !refill;
    eject_hi  = (state_q == DISP_HI) && (gap_q == 16'd0);
    eject_lo  = (state_q == DISP_LO) && (gap_q == 16'd0);
    done      = (state_q == DONE);
    status    = status_q;
    hi_count  = hi_q;
    lo_count  = lo_q;
  end

`ifdef DISPENSER_AUDIT_EN
  assign total_dispensed = total_q;
`endif

  // Next-state, planning arithmetic and eject pacing.
  always_comb begin
    state_n   = state_q;
    rem_n     = rem_q;
    plan_hi_n = plan_hi_q;
    plan_lo_n = plan_lo_q;
    hi_n      = hi_q;
    lo_n      = lo_q;
    gap_n     = gap_q;
    first_n   = first_q;
    status_n  = status_q;
    amount_n  = amount_q;
`ifdef DISPENSER_AUDIT_EN
    total_n   = total_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (refill) begin
          hi_n = CASSETTE_INIT;
          lo_n = CASSETTE_INIT;
        end else if (req_valid) begin
          rem_n     = req_amount;
          amount_n  = req_amount;
          plan_hi_n = 8'd0;
          plan_lo_n = 8'd0;
          first_n   = 1'b1;
          state_n   = PLAN;
        end
      end
      PLAN: begin
        first_n = 1'b0;
        if (first_q && rem_q == 16'd0) begin
          status_n = ST_ZERO;
          state_n  = DONE;
        end else if (rem_q >= DENOM_HI && plan_hi_q < hi_q) begin
          rem_n     = rem_q - DENOM_HI;
          plan_hi_n = plan_hi_q + 8'd1;
        end else if (rem_q >= DENOM_LO && plan_lo_q < lo_q) begin
          rem_n     = rem_q - DENOM_LO;
          plan_lo_n = plan_lo_q + 8'd1;
        end else if (rem_q == 16'd0) begin
          gap_n   = 16'd0;
          state_n = (plan_hi_q == 8'd0) ? DISP_LO : DISP_HI;
        end else begin
          status_n = ST_UNSERV;
          state_n  = DONE;
        end
      end
      DISP_HI: begin
        if (gap_q == 16'd0) begin
          hi_n      = hi_q - 8'd1;
          plan_hi_n = plan_hi_q - 8'd1;
          gap_n     = GAP_M1;
        end else begin
          gap_n = gap_q - 16'd1;
        end
        if (gap_n == 16'd0 && plan_hi_n == 8'd0) begin
          if (plan_lo_q != 8'd0) begin
            state_n = DISP_LO;
          end else begin
            status_n = ST_OK;
            state_n  = DONE;
          end
        end
      end
      DISP_LO: begin
        if (gap_q == 16'd0) begin
          lo_n      = lo_q - 8'd1;
          plan_lo_n = plan_lo_q - 8'd1;
          gap_n     = GAP_M1;
        end else begin
          gap_n = gap_q - 16'd1;
        end
        if (gap_n == 16'd0 && plan_lo_n == 8'd0) begin
          status_n = ST_OK;
          state_n  = DONE;
        end
      end
      DONE: begin
`ifdef DISPENSER_AUDIT_EN
        if (status_q == ST_OK)
          total_n = total_q + {16'd0, amount_q};
`endif
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rem_q     <= 16'd0;
      plan_hi_q <= 8'd0;
      plan_lo_q <= 8'd0;
      hi_q      <= CASSETTE_INIT;
      lo_q      <= CASSETTE_INIT;
      gap_q     <= 16'd0;
      first_q   <= 1'b0;
      status_q  <= ST_OK;
      amount_q  <= 16'd0;
`ifdef DISPENSER_AUDIT_EN
      total_q   <= 32'd0;
`endif
    end else begin
      state_q   <= state_n;
      rem_q     <= rem_n;
      plan_hi_q <= plan_hi_n;
      plan_lo_q <= plan_lo_n;
      hi_q      <= hi_n;
      lo_q      <= lo_n;
      gap_q     <= gap_n;
      first_q   <= first_n;
      status_q  <= status_n;
      amount_q  <= amount_n;
`ifdef DISPENSER_AUDIT_EN
      total_q   <= total_n;
`endif
    end
  end

endmodule

// File: doc/cash_dispenser.md
# cash_dispenser

Note-dispensing controller at the far end of the ATM withdraw path. It accepts a withdraw amount over a valid/ready handshake and splits it greedily into high and low denomination notes from two finite cassettes. It pulses one eject strobe per note, then returns a one-cycle completion with a status code. The ATM control FSM issues the requests; the mechanical note feeder consumes the eject strobes.

## Interface
Parameters:
- `DENOM_HI`, default 100: value of a high-denomination note (16-bit).
- `DENOM_LO`, default 20: value of a low-denomination note. Must be nonzero and less than `DENOM_HI`.
- `CASSETTE_INIT`, default 50: notes per cassette after reset or refill. Must be ≤ 255.
- `EJECT_GAP`, default 4: cycles between successive eject pulses. Must be ≥ 1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: **synchronous, active-low reset**.
- `req_valid` in 1: withdraw request valid.
- `req_amount` in 16: requested amount, unsigned.
- `req_ready` out 1: request can be accepted.
- `refill` in 1: reload both cassettes; honoured in IDLE only.
- `eject_hi` out 1: one-cycle pulse, eject one high note.
- `eject_lo` out 1: one-cycle pulse, eject one low note.
- `done` out 1: one-cycle completion pulse.
- `status` out 2: result, valid while `done`=1. 0 OK, 1 ERR_ZERO, 2 ERR_UNSERVABLE.
- `hi_count` out 8: high notes remaining.
- `lo_count` out 8: low notes remaining.
- `total_dispensed` out 32: present only with `DISPENSER_AUDIT_EN`.

## Operation
- Reset values:
  - State IDLE; `hi_count` = `lo_count` = `CASSETTE_INIT`.
  - `eject_hi`, `eject_lo`, `done` = 0; `status` = 0; `total_dispensed` = 0.
  - Reset mid-operation abandons pending ejects and never produces `done`.
- States: IDLE, PLAN, DISP_HI, DISP_LO, DONE.
- IDLE:
  - `req_ready` = (state==IDLE) && !`refill`, combinational.
  - `refill`=1 reloads both counts next edge. Refill wins over a simultaneous request, which is not accepted.
  - On `req_valid`&&`req_ready`: latch `req_amount` into `rem`, clear `plan_hi`/`plan_lo`, go to PLAN.
- PLAN, one step per cycle:
  - If `rem`==0 on the first PLAN cycle: ERR_ZERO, go to DONE.
  - Else if `rem`≥`DENOM_HI` and `plan_hi`<`hi_count`: `rem`-=`DENOM_HI`, `plan_hi`++.
  - Else if `rem`≥`DENOM_LO` and `plan_lo`<`lo_count`: `rem`-=`DENOM_LO`, `plan_lo`++.
  - Else if `rem`==0: go to DISP_HI (or DISP_LO if `plan_hi`==0).
  - Else: ERR_UNSERVABLE, go to DONE.
  - PLAN never modifies `hi_count`/`lo_count`.
- DISP_HI / DISP_LO:
  - Emit one eject pulse, decrement the matching count and plan counter on the same edge.
  - Wait `EJECT_GAP`-1 idle cycles, repeat until the plan counter is 0.
  - DISP_HI then moves to DISP_LO if `plan_lo`>0, else to DONE.
- DONE:
  - `done`=1 with `status` for exactly one cycle, then IDLE.
  - `status` holds its value until the next `done`.
- Arithmetic: `rem` is 16-bit unsigned. Subtraction happens only when `rem` ≥ the denomination, so it never wraps. Plan counters are 8-bit and bounded by the counts.
- `refill` and `req_valid` outside IDLE are ignored; requests are never queued.

## Timing
- Accept edge T: PLAN occupies T+1 … T+1+`plan_hi`+`plan_lo`. The decision cycle is the last of these.
- ERR_ZERO: `done` in cycle T+2.
- OK: first eject pulse on the cycle after the decision cycle. Consecutive ejects are spaced exactly `EJECT_GAP` cycles, including across the hi→lo transition.
- `done` asserts `EJECT_GAP` cycles after the last eject pulse.
- Counts update on the eject pulse edge and are visible the following cycle.
- `eject_hi` and `eject_lo` are never asserted together.

## Configuration
- `DISPENSER_AUDIT_EN` defined:
  - Adds the `total_dispensed` port.
  - Increments by the latched request amount in the DONE cycle when `status`==OK.
  - Cleared only by reset; wraps modulo 2^32.
- Undefined: no port, no counter logic; behaviour otherwise identical.

## Test plan
All scenarios use DENOM_HI=100, DENOM_LO=20, EJECT_GAP=4, CASSETTE_INIT=50 unless stated.
- Request 260 → 2 `eject_hi` then 3 `eject_lo`, each 4 cycles apart → `done`, `status`=0, `hi_count`=48, `lo_count`=47.
- Request 130 → `done`, `status`=2, no ejects, counts unchanged at 50/50. Request 0 → `done` at T+2 with `status`=1.
- CASSETTE_INIT=3:
  - Request 300 → 3 hi ejects, OK, `hi_count`=0.
  - Request 100 → `status`=2, `lo_count` stays 3.
  - Pulse `refill` together with `req_valid` → request not accepted (`req_ready`=0), counts become 3/3.
  - Request 100 again → 1 hi eject, OK.
- Hold `req_valid` high with 120 during a 260 dispense → a second request is accepted only after `done`. Total ejects: 3 hi, 4 lo.
- Assert `rst`=0 for one cycle after the 2nd eject of a 260 request → no further ejects, no `done`, counts 50/50, `req_ready`=1 the next cycle.
- With `DISPENSER_AUDIT_EN`: 260 OK, 130 error, 40 OK → `total_dispensed`=300.
